warp_issue_unit: RTL and testbench
==================================

// Module: warp_issue_unit
// PURPOSE
//  Upstream issue stage for lane_array. Buffers incoming warp instructions in a small FIFO,
//  applies the current active-lane mask, and drives execute/instruction/lane_enable.
//  Holds each issued op stable until the lane array reports ready, then issues the next one.
//  Retires zero-mask instructions without touching the lanes.
// PARAMETERS
//  NUM_LANES   warp_pkg::NUM_LANES_DEFAULT  lanes driven; width of mask and lane_enable
//  FIFO_DEPTH  4                            instruction buffer entries; power of 2, >=2
//  CNT_WIDTH   16                           width of retired/skipped counters
//  TIMEOUT     1024                         watchdog limit in cycles (WARP_ISSUE_TIMEOUT_EN only)
// PORTS
//  clk            in   1          clock
//  rst_n          in   1          async active-low reset
//  instr_valid    in   1          upstream instruction valid
//  instr_data     in   32         upstream instruction word
//  instr_ready    out  1          FIFO can accept; equals !full
//  mask_we        in   1          write active-lane mask
//  mask_in        in   NUM_LANES  new active-lane mask
//  flush          in   1          sync flush of buffered (un-issued) instructions
//  execute        out  1          one-cycle issue pulse to lane_array
//  instruction    out  32         issued instruction; held until the op completes
//  lane_enable    out  NUM_LANES  mask for the in-flight op; held until the op completes
//  lane_ready     in   1          lane_array ready (AND of enabled lanes)
//  busy           out  1          FSM not IDLE, or FIFO not empty
//  retired_count  out  CNT_WIDTH  ops completed by lanes; wraps
//  skipped_count  out  CNT_WIDTH  zero-mask ops retired without issue; wraps
//  timeout_err    out  1          sticky watchdog flag; tied 0 when the macro is undefined
// BEHAVIOUR
//  Reset (async, rst_n=0): FIFO empty, instr_ready=1, execute=0, instruction=0, lane_enable=0,
//   active mask = all ones, FSM=IDLE, both counters 0, timeout_err=0, busy=0.
//   Reset mid-op abandons the op; no retire is counted.
//  FIFO: push on instr_valid&&instr_ready. An entry pushed into an empty FIFO is visible to
//   the FSM the next cycle (no bypass). Full: instr_ready=0, and a push attempt is ignored.
//   Pointers wrap modulo FIFO_DEPTH, with an extra bit to tell full from empty.
//  Mask: mask_we loads mask_in at the clock edge. An issue in the same cycle uses the old mask.
//   The in-flight lane_enable is never altered by mask_we.
//  FSM states:
//   IDLE:  FIFO non-empty and lane_ready=1 -> pop head.
//          mask!=0: latch instruction/lane_enable, execute=1 for exactly this cycle's output
//          (registered, so visible next cycle) -> WAIT.
//          mask==0: skipped_count+1, no execute, stay IDLE. One pop per cycle max.
//   WAIT:  lane_ready is ignored in the first WAIT cycle (the cycle execute is high).
//          From the 2nd WAIT cycle on, lane_ready=1 -> retired_count+1 -> IDLE.
//          instruction/lane_enable keep their last value in IDLE.
//   Minimum back-to-back issue interval: 3 cycles (execute, wait>=1, idle/pop).
//  flush: clears the FIFO the same edge; a push in the flush cycle is dropped.
//   flush in WAIT does not abort the in-flight op. Flush has priority over pop.
//  busy = (state!=IDLE) || !empty.
//  Counters wrap from 2^CNT_WIDTH-1 to 0 silently.
// CONFIGURATION
//  WARP_ISSUE_TIMEOUT_EN defined:
//   - Cycle counter runs in WAIT. Reaching TIMEOUT cycles sets sticky timeout_err and
//     forces WAIT->IDLE without a retire; the next instruction may then issue.
//   - timeout_err is cleared only by reset.
//  WARP_ISSUE_TIMEOUT_EN undefined: no counter, timeout_err=0, WAIT waits indefinitely.
// TESTING
//  1 Reset, then push 0xA1 (mask all ones, lane_ready=1) -> execute pulse 2 cycles after push;
//    instruction=0xA1, lane_enable=all ones; retired_count=1 after lane_ready re-asserts.
//  2 Push 5 ops while lane_ready=0, FIFO_DEPTH=4 -> instr_ready=0 after the 4th; 5th held
//    upstream; after drain, ops issue in FIFO order.
//  3 mask_we with mask_in=0, push 0x33 -> no execute, skipped_count=1, retired_count unchanged.
//  4 mask_we=1 (mask_in=0x5) in the same cycle as an issue pop -> that op uses the old mask;
//    the next op gets lane_enable=0x5.
//  5 flush during WAIT with 3 buffered ops -> in-flight op retires; FIFO empty;
//    busy=0 after retire.
//  6 (macro on, TIMEOUT=8) hold lane_ready=0 after execute -> timeout_err=1 after 8 WAIT cycles,
//    FSM back to IDLE, retired_count unchanged.

Source files
------------

// File: rtl/warp_issue_unit.sv
// warp_issue_unit: issue stage in front of lane_array.
// Buffers instructions in a small FIFO and applies the active-lane mask. It issues one op at a
// time and holds instruction/lane_enable until the lanes report ready. Zero-mask ops are retired
// as "skipped" and never reach the lanes.
// Optional feature: define WARP_ISSUE_TIMEOUT_EN to add a WAIT-state watchdog (timeout_err_o).
// NUM_LANES mirrors warp_pkg::NUM_LANES_DEFAULT so this file stays self-contained.

module warp_issue_unit #(
    parameter int unsigned NUM_LANES  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid_i,
    input  logic [31:0]          instr_data_i,
    output logic                 instr_ready_o,
    input  logic                 mask_we_i,
    input  logic [NUM_LANES-1:0] mask_in_i,
    input  logic                 flush_i,
    output logic                 execute_o,
    output logic [31:0]          instruction_o,
    output logic [NUM_LANES-1:0] lane_enable_o,
    input  logic                 lane_ready_i,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] retired_count_o,
    output logic [CNT_WIDTH-1:0] skipped_count_o,
    output logic                 timeout_err_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PtrOne = 1;
    localparam logic [CNT_WIDTH-1:0] CntOne = 1;

    typedef enum logic {StIdle, StWait} state_e;

    state_e               state_q;
    logic                 execute_q;
    logic [31:0]          instr_q;
    logic [NUM_LANES-1:0] lane_en_q;
    logic [NUM_LANES-1:0] mask_q;
    logic [CNT_WIDTH-1:0] retired_q;
    logic [CNT_WIDTH-1:0] skipped_q;

    logic [31:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wptr_q;
    logic [AW:0] rptr_q;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic [31:0] head;
    logic        retire;
    logic        timeout_hit;

    // The extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head  = mem_q[rptr_q[AW-1:0]];

    assign push   = instr_valid_i && !full && !flush_i;
    assign pop    = (state_q == StIdle) && !empty && lane_ready_i && !flush_i;
    // lane_ready is ignored while execute is still high (first WAIT cycle).
    assign retire = (state_q == StWait) && !execute_q && lane_ready_i;

    // FIFO storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= instr_data_i;
        end
    end

    // FIFO pointers; flush empties the buffer and wins over push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PtrOne;
            if (pop)  rptr_q <= rptr_q + PtrOne;
        end
    end

    // Active-lane mask; an issue in the same cycle still sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '1;
        end else if (mask_we_i) begin
            mask_q <= mask_in_i;
        end
    end

    // Issue FSM with registered execute/instruction/lane_enable and retire/skip counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            execute_q <= 1'b0;
            instr_q   <= '0;
            lane_en_q <= '0;
            retired_q <= '0;
            skipped_q <= '0;
        end else begin
            execute_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        if (mask_q != '0) begin
                            instr_q   <= head;
                            lane_en_q <= mask_q;
                            execute_q <= 1'b1;
                            state_q   <= StWait;
                        end else begin
                            skipped_q <= skipped_q + CntOne;
                        end
                    end
                end
                StWait: begin
                    if (retire) begin
                        retired_q <= retired_q + CntOne;
                        state_q   <= StIdle;
                    end else if (timeout_hit) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef WARP_ISSUE_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] WaitLast = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] WaitOne  = 1;

    logic [TW-1:0] wait_cnt_q;
    logic          timeout_err_q;

    // Fires in the TIMEOUT-th WAIT cycle unless the lanes retire the op in that same cycle.
    assign timeout_hit = (state_q == StWait) && !retire && (wait_cnt_q == WaitLast);

    // Watchdog: counts WAIT cycles; the error flag is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (state_q == StWait && !retire && !timeout_hit) begin
                wait_cnt_q <= wait_cnt_q + WaitOne;
            end else begin
                wait_cnt_q <= '0;
            end
            if (timeout_hit) timeout_err_q <= 1'b1;
        end
    end

    assign timeout_err_o = timeout_err_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT == 0);
    assign timeout_hit    = 1'b0;
    assign timeout_err_o  = 1'b0;
`endif

    assign instr_ready_o   = !full;
    assign execute_o       = execute_q;
    assign instruction_o   = instr_q;
    assign lane_enable_o   = lane_en_q;
    assign busy_o          = (state_q != StIdle) || !empty;
    assign retired_count_o = retired_q;
    assign skipped_count_o = skipped_q;

endmodule

// File: tb/tb_warp_issue_unit.sv
// Directed bench for warp_issue_unit (NUM_LANES=8, FIFO_DEPTH=4, CNT_WIDTH=16, TIMEOUT=8).
// Table of per-cycle vectors for issue/skip/mask timing, then hand sequences for FIFO-full
// back-pressure, flush during WAIT, the watchdog (or its absence), and reset mid-op.

module tb_warp_issue_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic        instr_ready;
    logic        mask_we;
    logic [7:0]  mask_in;
    logic        flush;
    logic        execute;
    logic [31:0] instruction;
    logic [7:0]  lane_enable;
    logic        lane_ready;
    logic        busy;
    logic [15:0] retired_count;
    logic [15:0] skipped_count;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    warp_issue_unit #(
        .NUM_LANES (8),
        .FIFO_DEPTH(4),
        .CNT_WIDTH (16),
        .TIMEOUT   (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_valid_i  (instr_valid),
        .instr_data_i   (instr_data),
        .instr_ready_o  (instr_ready),
        .mask_we_i      (mask_we),
        .mask_in_i      (mask_in),
        .flush_i        (flush),
        .execute_o      (execute),
        .instruction_o  (instruction),
        .lane_enable_o  (lane_enable),
        .lane_ready_i   (lane_ready),
        .busy_o         (busy),
        .retired_count_o(retired_count),
        .skipped_count_o(skipped_count),
        .timeout_err_o  (timeout_err)
    );

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        mwe;
        logic [7:0]  min;
        logic        fl;
        logic        lr;
        logic        rdy;
        logic        exe;
        logic [31:0] ins;
        logic [7:0]  le;
        logic        bsy;
        logic [15:0] ret;
        logic [15:0] skp;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    function automatic vec_t mk(logic v, logic [31:0] d, logic mwe, logic [7:0] min, logic fl,
                                logic lr, logic rdy, logic exe, logic [31:0] ins, logic [7:0] le,
                                logic bsy, logic [15:0] ret, logic [15:0] skp);
        vec_t r;
        r.v = v; r.d = d; r.mwe = mwe; r.min = min; r.fl = fl; r.lr = lr;
        r.rdy = rdy; r.exe = exe; r.ins = ins; r.le = le; r.bsy = bsy; r.ret = ret; r.skp = skp;
        return r;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_valid = 1'b0;
        instr_data  = '0;
        mask_we     = 1'b0;
        mask_in     = '0;
        flush       = 1'b0;
    endtask

    logic [31:0] got [$];
    int          exp_ret;
    bit          accepted;
    int          budget;

    initial begin
        rst_n      = 1'b0;
        lane_ready = 1'b0;
        idle_inputs();

        // Cycle-by-cycle vectors: inputs for the cycle, outputs expected after its edge.
        vecs[0]  = mk(1, 32'hA1, 0, 8'h00, 0, 1,  1, 0, 32'h00, 8'h00, 1, 0, 0);
        vecs[1]  = mk(0, 32'h00, 0, 8'h00, 0, 1,  1, 1, 32'hA1, 8'hFF, 1, 0, 0);
        vecs[2]  = mk(0, 32'h00, 0, 8'h00, 0, 0,  1, 0, 32'hA1, 8'hFF, 1, 0, 0);
        vecs[3]  = mk(0, 32'h00, 0, 8'h00, 0, 1,  1, 0, 32'hA1, 8'hFF, 0, 1, 0);
        vecs[4]  = mk(1, 32'h33, 1, 8'h00, 0, 1,  1, 0, 32'hA1, 8'hFF, 1, 1, 0);
        vecs[5]  = mk(0, 32'h00, 0, 8'h00, 0, 1,  1, 0, 32'hA1, 8'hFF, 0, 1, 1);
        vecs[6]  = mk(1, 32'h44, 1, 8'hFF, 0, 1,  1, 0, 32'hA1, 8'hFF, 1, 1, 1);
        vecs[7]  = mk(1, 32'h55, 1, 8'h05, 0, 1,  1, 1, 32'h44, 8'hFF, 1, 1, 1);
        vecs[8]  = mk(0, 32'h00, 0, 8'h00, 0, 1,  1, 0, 32'h44, 8'hFF, 1, 1, 1);
        vecs[9]  = mk(0, 32'h00, 0, 8'h00, 0, 1,  1, 0, 32'h44, 8'hFF, 1, 2, 1);
        vecs[10] = mk(0, 32'h00, 0, 8'h00, 0, 1,  1, 1, 32'h55, 8'h05, 1, 2, 1);
        vecs[11] = mk(0, 32'h00, 1, 8'h0F, 0, 1,  1, 0, 32'h55, 8'h05, 1, 2, 1);
        vecs[12] = mk(0, 32'h00, 0, 8'h00, 0, 1,  1, 0, 32'h55, 8'h05, 0, 3, 1);
        vecs[13] = mk(1, 32'h66, 0, 8'h00, 1, 1,  1, 0, 32'h55, 8'h05, 0, 3, 1);
        vecs[14] = mk(0, 32'h00, 0, 8'h00, 0, 1,  1, 0, 32'h55, 8'h05, 0, 3, 1);

        tick();
        tick();
        check("reset_state",
              {instr_ready, execute, instruction, lane_enable, busy, retired_count,
               skipped_count, timeout_err},
              {1'b1, 1'b0, 32'h0, 8'h00, 1'b0, 16'd0, 16'd0, 1'b0});
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            instr_valid = vecs[i].v;
            instr_data  = vecs[i].d;
            mask_we     = vecs[i].mwe;
            mask_in     = vecs[i].min;
            flush       = vecs[i].fl;
            lane_ready  = vecs[i].lr;
            tick();
            check($sformatf("vec%0d", i),
                  {instr_ready, execute, instruction, lane_enable, busy, retired_count,
                   skipped_count},
                  {vecs[i].rdy, vecs[i].exe, vecs[i].ins, vecs[i].le, vecs[i].bsy,
                   vecs[i].ret, vecs[i].skp});
        end
        idle_inputs();
        exp_ret = 3;

        // FIFO full back-pressure; active mask is now 0x0F.
        lane_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            instr_valid = 1'b1;
            instr_data  = 32'hB0 + i;
            tick();
        end
        check("full_ready_low", {95'b0, instr_ready}, 96'd0);
        instr_data = 32'hB4;
        tick();
        tick();
        check("fifth_held", {94'b0, instr_ready, execute}, 96'd0);
        lane_ready = 1'b1;
        budget = 60;
        while (got.size() < 5 && budget > 0) begin
            accepted = instr_valid && instr_ready;
            tick();
            if (accepted) instr_valid = 1'b0;
            if (execute) begin
                got.push_back(instruction);
                check("drain_lane_en", {88'b0, lane_enable}, {88'b0, 8'h0F});
            end
            budget--;
        end
        check("drain_count", 96'(got.size()), 96'd5);
        for (int i = 0; i < got.size(); i++) begin
            check($sformatf("drain_order%0d", i), {64'b0, got[i]}, {64'b0, 32'hB0 + i});
        end
        budget = 10;
        while (busy && budget > 0) begin
            tick();
            budget--;
        end
        exp_ret += 5;
        check("drain_retired", {80'b0, retired_count}, 96'(exp_ret));

        // Flush while an op is in WAIT with three buffered behind it.
        instr_valid = 1'b1;
        instr_data  = 32'hC0;
        tick();
        instr_data = 32'hC1;
        tick();
        check("flush_issue", {63'b0, execute, instruction}, {63'b0, 1'b1, 32'hC0});
        lane_ready = 1'b0;
        instr_data = 32'hC2;
        tick();
        instr_data = 32'hC3;
        tick();
        instr_data = 32'hC9;
        flush      = 1'b1;
        tick();
        idle_inputs();
        check("flush_keeps_wait", {79'b0, busy, retired_count}, {79'b0, 1'b1, 16'(exp_ret)});
        lane_ready = 1'b1;
        tick();
        exp_ret += 1;
        check("flush_retire", {79'b0, busy, retired_count}, {79'b0, 1'b0, 16'(exp_ret)});
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("flush_no_issue%0d", i), {94'b0, execute, busy}, 96'd0);
        end

        // Watchdog: lanes never report ready after an issue.
        instr_valid = 1'b1;
        instr_data  = 32'hE0;
        tick();
        instr_valid = 1'b0;
        tick();
        check("wd_issue", {63'b0, execute, instruction}, {63'b0, 1'b1, 32'hE0});
        lane_ready = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("wd_before_limit", {94'b0, busy, timeout_err}, {94'b0, 1'b1, 1'b0});
        tick();
`ifdef WARP_ISSUE_TIMEOUT_EN
        check("wd_fired", {78'b0, busy, timeout_err, retired_count},
              {78'b0, 1'b0, 1'b1, 16'(exp_ret)});
        lane_ready = 1'b1;
        tick();
        tick();
        check("wd_sticky", {95'b0, timeout_err}, {95'b0, 1'b1});
`else
        for (int i = 0; i < 4; i++) tick();
        check("wd_absent", {78'b0, busy, timeout_err, retired_count},
              {78'b0, 1'b1, 1'b0, 16'(exp_ret)});
        lane_ready = 1'b1;
        tick();
        exp_ret += 1;
        check("wd_absent_retire", {79'b0, busy, retired_count}, {79'b0, 1'b0, 16'(exp_ret)});
`endif

        // Reset in the middle of an op abandons it; mask returns to all ones.
        mask_we = 1'b1;
        mask_in = 8'h03;
        tick();
        mask_we     = 1'b0;
        instr_valid = 1'b1;
        instr_data  = 32'hD0;
        tick();
        instr_valid = 1'b0;
        tick();
        check("rst_pre_issue", {55'b0, execute, instruction, lane_enable},
              {55'b0, 1'b1, 32'hD0, 8'h03});
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_op",
              {instr_ready, execute, instruction, lane_enable, busy, retired_count,
               skipped_count, timeout_err},
              {1'b1, 1'b0, 32'h0, 8'h00, 1'b0, 16'd0, 16'd0, 1'b0});
        tick();
        rst_n       = 1'b1;
        instr_valid = 1'b1;
        instr_data  = 32'hD1;
        tick();
        instr_valid = 1'b0;
        tick();
        check("rst_mask_ones", {55'b0, execute, instruction, lane_enable},
              {55'b0, 1'b1, 32'hD1, 8'hFF});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
